// File: rtl/kpd_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional build macro KPD_AUTOREPEAT_EN enables held-key auto-repeat in keypad_scan_ctrl.
package kpd_pkg;

    localparam int unsigned CODE_W       = 4;
    localparam int unsigned REPEAT_SCANS = 500;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StEmit,
        StHold
    } kpd_state_e;

    // Key codes indexed by {col_idx, row_idx}; entry 0 is col0/row0
    localparam logic [15:0][CODE_W-1:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // col3 rows 3..0
        4'hE, 4'h9, 4'h6, 4'h3,   // col2 rows 3..0
        4'hF, 4'h8, 4'h5, 4'h2,   // col1 rows 3..0
        4'h0, 4'h7, 4'h4, 4'h1    // col0 rows 3..0
    };

    // Lowest-index active-low row wins when several rows are pulled down
    function automatic logic [1:0] row_prio(input logic [3:0] row);
        if (!row[0]) return 2'd0;
        else if (!row[1]) return 2'd1;
        else if (!row[2]) return 2'd2;
        else return 2'd3;
    endfunction

endpackage

// File: rtl/kpd_tick_gen.sv
// Free-running divider: tick is high for one clk every SCAN_DIV cycles.
// Configuration macro KPD_AUTOREPEAT_EN has no effect on this block.
module kpd_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Count 0..SCAN_DIV-1 and wrap
    always_comb begin
        timer_d = (timer_q == LAST) ? '0 : timer_q + TW'(1);
    end

    // Timer register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    // The wrap cycle is the scan step
    always_comb begin
        tick = (timer_q == LAST);
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row decode, press/release debounce and
// a 4-digit key history. Define KPD_AUTOREPEAT_EN to re-emit a held key every
// REPEAT_SCANS scan steps; without it each press emits exactly once.
module keypad_scan_ctrl
    import kpd_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row,
    input  logic              clr,
    output logic [3:0]        col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic [CODE_W-1:0] key1,
    output logic [CODE_W-1:0] key2,
    output logic [CODE_W-1:0] key3,
    output logic [CODE_W-1:0] key4,
    output logic              pressed
);

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

    logic tick;

    kpd_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    kpd_state_e        state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic [CODE_W-1:0] key1_q, key1_d, key2_q, key2_d, key3_q, key3_d, key4_q, key4_d;

    logic              hit;
    logic [1:0]        row_idx;
    logic [CODE_W-1:0] cur_code;
    logic [3:0]        cnt_inc;

`ifdef KPD_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SCANS);
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [RPT_W-1:0] rpt_inc;
    assign rpt_inc = rpt_q + RPT_W'(1);
`endif

    // Decode the active column's rows into a hit flag and key code
    always_comb begin
        hit      = (row != 4'hF);
        row_idx  = row_prio(row);
        cur_code = KEY_MAP[{col_idx_q, row_idx}];
        cnt_inc  = cnt_q + 4'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StScan;
        else       state_q <= state_d;
    end

    // Next-state and scan datapath; decisions are taken only on tick except EMIT
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        key_code_d = key_code_q;
`ifdef KPD_AUTOREPEAT_EN
        rpt_d      = rpt_q;
`endif
        unique case (state_q)
            StScan: begin
                if (tick) begin
                    if (hit) begin
                        cand_d = cur_code;
                        if (DEB_LAST == 4'd1) begin
                            state_d    = StEmit;
                            key_code_d = cur_code;
                            cnt_d      = '0;
                        end else begin
                            state_d = StDebounce;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (hit && (cur_code == cand_q)) begin
                        if (cnt_inc == DEB_LAST) begin
                            state_d    = StEmit;
                            key_code_d = cand_q;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d   = StScan;
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end
                end
            end
            StEmit: begin
                state_d = StHold;
                cnt_d   = '0;
`ifdef KPD_AUTOREPEAT_EN
                rpt_d   = '0;
`endif
            end
            StHold: begin
                if (tick) begin
                    if (hit) begin
                        // Any hit, even a different key, keeps the press alive
                        cnt_d = '0;
`ifdef KPD_AUTOREPEAT_EN
                        if (cur_code == cand_q) begin
                            if (rpt_inc == RPT_LAST) begin
                                state_d    = StEmit;
                                key_code_d = cand_q;
                                rpt_d      = '0;
                            end else begin
                                rpt_d = rpt_inc;
                            end
                        end else begin
                            rpt_d = '0;
                        end
`endif
                    end else begin
`ifdef KPD_AUTOREPEAT_EN
                        rpt_d = '0;
`endif
                        if (cnt_inc == DEB_LAST) begin
                            state_d   = StScan;
                            col_idx_d = 2'd0;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
            end
            default: state_d = StScan;
        endcase
    end

    // History shift on EMIT; clr wins over old digits but not the new one
    always_comb begin
        key1_d = key1_q;
        key2_d = key2_q;
        key3_d = key3_q;
        key4_d = key4_q;
        if (state_q == StEmit) begin
            key1_d = key2_q;
            key2_d = key3_q;
            key3_d = key4_q;
            key4_d = cand_q;
        end
        if (clr) begin
            key1_d = '0;
            key2_d = '0;
            key3_d = '0;
            key4_d = (state_q == StEmit) ? cand_q : '0;
        end
    end

    // Datapath and history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            col_idx_q  <= '0;
            cnt_q      <= '0;
            cand_q     <= '0;
            key_code_q <= '0;
            key1_q     <= '0;
            key2_q     <= '0;
            key3_q     <= '0;
            key4_q     <= '0;
`ifdef KPD_AUTOREPEAT_EN
            rpt_q      <= '0;
`endif
        end else begin
            col_idx_q  <= col_idx_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            key_code_q <= key_code_d;
            key1_q     <= key1_d;
            key2_q     <= key2_d;
            key3_q     <= key3_d;
            key4_q     <= key4_d;
`ifdef KPD_AUTOREPEAT_EN
            rpt_q      <= rpt_d;
`endif
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        col       = ~(4'b0001 << col_idx_q);
        key_valid = (state_q == StEmit);
        pressed   = (state_q != StScan);
        key_code  = key_code_q;
        key1      = key1_q;
        key2      = key2_q;
        key3      = key3_q;
        key4      = key4_q;
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// Define KPD_AUTOREPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic       clr;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code, key1, key2, key3, key4;
    logic       pressed;
    logic [15:0] hist;

    keypad_scan_ctrl #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .clr      (clr),
        .col      (col),
        .key_valid(key_valid),
        .key_code (key_code),
        .key1     (key1),
        .key2     (key2),
        .key3     (key3),
        .key4     (key4),
        .pressed  (pressed)
    );

    always #5 clk = ~clk;

    assign hist = {key1, key2, key3, key4};

    // Keypad model: held[{c,r}] closes the switch between column c and row r
    logic [15:0] held;
    logic        raw_en;
    logic [3:0]  raw_row;

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (held[c*4+r]) row[r] = 1'b0;
                end
            end
        end
        if (raw_en) row = raw_row;
    end

    int kv_count = 0;
    always @(negedge clk) if (key_valid === 1'b1) kv_count++;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_hist;

    typedef struct {
        int         c;
        int         r;
        logic [3:0] code;
    } press_t;

    press_t seq [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_valid(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit && !ok) begin
            @(negedge clk);
            cyc++;
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit && !ok) begin
            @(negedge clk);
            cyc++;
            if (pressed === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic release_all(input string tag);
        bit ok;
        held   = '0;
        raw_en = 1'b0;
        wait_idle(100, ok);
        check({tag, "_released"}, 32'(ok), 32'd1);
        check({tag, "_col_after"}, 32'(col), 32'hE);
    endtask

    task automatic press_key(input int c, input int r, input logic [3:0] code, input string tag);
        int cyc;
        bit ok;
        int base;
        base = kv_count;
        held = 16'(1) << (c * 4 + r);
        wait_valid(200, cyc, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_code"}, 32'(key_code), 32'(code));
        @(negedge clk);
        exp_hist = {exp_hist[11:0], code};
        check({tag, "_hist"}, 32'(hist), 32'(exp_hist));
        repeat (30) @(negedge clk);
        release_all(tag);
        check({tag, "_pulses"}, 32'(kv_count - base), 32'd1);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  base;

        seq[0] = '{c: 0, r: 3, code: 4'h0};
        seq[1] = '{c: 1, r: 3, code: 4'hF};
        seq[2] = '{c: 2, r: 3, code: 4'hE};
        seq[3] = '{c: 3, r: 2, code: 4'hC};
        seq[4] = '{c: 0, r: 0, code: 4'h1};
        seq[5] = '{c: 1, r: 0, code: 4'h2};
        seq[6] = '{c: 2, r: 0, code: 4'h3};
        seq[7] = '{c: 3, r: 0, code: 4'hA};
        seq[8] = '{c: 3, r: 3, code: 4'hD};

        // Reset with every row pulled low
        reset = 1'b1; clr = 1'b0; held = '0; raw_en = 1'b1; raw_row = 4'h0;
        exp_hist = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_col", 32'(col), 32'hE);
            check("rst_valid", 32'(key_valid), 32'd0);
            check("rst_hist", 32'(hist), 32'd0);
            check("rst_pressed", 32'(pressed), 32'd0);
            check("rst_code", 32'(key_code), 32'd0);
        end
        reset = 1'b0;
        base = kv_count;
        wait_valid(200, cyc, ok);
        check("post_rst_seen", 32'(ok), 32'd1);
        check("post_rst_latency", 32'(cyc), 32'd12);
        check("post_rst_code", 32'(key_code), 32'h1);
        @(negedge clk);
        exp_hist = 16'h0001;
        check("post_rst_hist", 32'(hist), 32'(exp_hist));
        repeat (40) @(negedge clk);
        check("post_rst_pulses", 32'(kv_count - base), 32'd1);
        release_all("post_rst");

        // Single press of '5'
        press_key(1, 1, 4'h5, "key5");

        // Bouncing '5': alternate samples never reach the debounce count
        base = kv_count;
        for (int i = 0; i < 12; i++) begin
            held = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            repeat (4) @(negedge clk);
        end
        check("bounce_no_valid", 32'(kv_count - base), 32'd0);
        press_key(1, 1, 4'h5, "bounce_stable");

        // Table of single presses
        for (int i = 0; i < 9; i++) begin
            press_key(seq[i].c, seq[i].r, seq[i].code, $sformatf("seq%0d", i));
        end
        check("hist_final", 32'(hist), 32'h23AD);

        // clr in the same cycle as EMIT of '7'
        held = 16'h0004;
        wait_valid(200, cyc, ok);
        check("clr_emit_seen", 32'(ok), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_hist = 16'h0007;
        check("clr_emit_hist", 32'(hist), 32'h0007);
        check("clr_emit_code", 32'(key_code), 32'h7);
        release_all("clr_emit");

        // Two rows low on col2: row0 wins; extra keys during HOLD are ignored
        base = kv_count;
        held = 16'h0300;
        wait_valid(200, cyc, ok);
        check("two_rows_seen", 32'(ok), 32'd1);
        check("two_rows_code", 32'(key_code), 32'h3);
        held = 16'h1700;
        repeat (40) @(negedge clk);
        held = 16'h0400;
        repeat (30) @(negedge clk);
        check("hold_still_pressed", 32'(pressed), 32'd1);
        check("hold_no_rollover", 32'(kv_count - base), 32'd1);
        release_all("two_rows");
        check("two_rows_hist", 32'(hist), 32'h0073);

        // clr outside EMIT leaves FSM and key_code alone
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_idle_hist", 32'(hist), 32'h0);
        check("clr_idle_code", 32'(key_code), 32'h3);
        check("clr_idle_pressed", 32'(pressed), 32'd0);
        exp_hist = '0;

`ifdef KPD_AUTOREPEAT_EN
        // Hold '9' for 1200 scan steps: initial emit plus two repeats
        base = kv_count;
        held = 16'h0400;
        repeat (4800) @(negedge clk);
        check("rpt_pulses", 32'(kv_count - base), 32'd3);
        check("rpt_hist", 32'(hist[11:0]), 32'h999);
        release_all("rpt");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
